vga_scaled_fb_reader: RTL and testbench
=======================================

// Module: vga_scaled_fb_reader
// PURPOSE
// Registered address generator and pixel gate between VGA_Driver1024x768 and buffer_ram_dp.
// Maps each VGA pixel position (posX/posY) to a frame-buffer address.
// - The FB_W x FB_H image is shown at integer scale SCALE.
// - Supports runtime X/Y mirroring.
// - Pixels outside the scaled image are blanked.
// Uses incremental counters only; no divider or modulo logic.
// PARAMETERS
// SCREEN_X   1024    active VGA width (pixels)
// SCREEN_Y   768     active VGA height (lines)
// FB_W       32      frame-buffer width (cells)
// FB_H       24      frame-buffer height (cells)
// SCALE      32      VGA pixels per cell, each axis; any integer >= 1
// AW         10      address width; 2**AW >= FB_W*FB_H
// DW         3       pixel width (RGB111)
// BG_COLOR   3'b000  colour driven outside the scaled image
// PORTS
// clk        in   1    pixel clock (clk75M)
// rst        in   1    synchronous reset, active low
// pos_x      in   12   VGA posX of the next pixel; advances 1 per clk in active area
// pos_y      in   12   VGA posY of the next pixel
// mode       in   2    bit0 mirror X, bit1 mirror Y; applied at frame start only
// pixel_in   in   DW   buffer_ram_dp data_out; 1-clk read latency
// addr_out   out  AW   buffer_ram_dp addr_out
// pixel_out  out  DW   pixel to VGA driver pixelIn
// in_image   out  1    high while pixel_out carries frame-buffer data
// frame_tick out  1    1-clk pulse when pos_y wraps to 0
// BEHAVIOUR
// - Reset (rst==0 at clk edge):
//   - Outputs: addr_out=0, pixel_out=BG_COLOR, in_image=0, frame_tick=0.
//   - Internal state: mode_q=0, all counters=0, pipeline valid bits=0.
// - X tracking: prev_x holds pos_x from the previous clk.
//   - pos_x==0: sub_x=0, cx=0, x_ok=1.
//   - pos_x==prev_x+1: sub_x++. When sub_x reaches SCALE-1, set sub_x=0 and cx++.
//     cx saturates at FB_W, which means "outside".
//   - pos_x>=SCREEN_X, or any other jump: x_ok=0 and counters hold.
// - Y tracking: counters update only when pos_y!=prev_y.
//   - pos_y==0: sub_y=0, cy=0.
//   - pos_y==prev_y+1: sub_y/cy advance like X, saturating at FB_H.
//   - Any other jump: y_ok=0 until the next pos_y==0.
// - Frame start: when pos_y==0 and prev_y!=0:
//   - frame_tick=1 for exactly 1 clk.
//   - mode_q<=mode.
//   - mode changes mid-frame are ignored.
// - Stage 1 (registered, +1 clk from pos): in_img1 = x_ok & y_ok & cx<FB_W & cy<FB_H & pos_y<SCREEN_Y.
//   - ex = mode_q[0] ? FB_W-1-cx : cx.
//   - ey = mode_q[1] ? FB_H-1-cy : cy.
//   - addr_out = ey*FB_W + ex, truncated to AW bits.
//   - When in_img1=0, addr_out holds its last value.
// - Stage 2 (+2 clk from pos):
//   - in_image <= in_img1.
//   - pixel_out <= in_img1 ? pixel_in : BG_COLOR, with pixel_in returned for the stage-1 addr.
// - Fixed latency: addr_out 1 clk, pixel_out/in_image 2 clk. The driver posX lookahead
//   must absorb 2 clk.
// - Boundaries:
//   - Last cell of a line (cx==FB_W-1, sub_x==SCALE-1) is followed by out-of-image if
//     FB_W*SCALE<SCREEN_X.
//   - With FB_W*SCALE==SCREEN_X, addr wraps to the line start at the next pos_x==0.
//   - Simultaneous pos_x==0 and pos_y change: both axes reload/advance in the same clk.
// - Reset mid-line: outputs reset next clk. Tracking resyncs at the next pos_x==0; Y stays
//   invalid until pos_y==0.
// TESTING
// 1 SCALE=32, mode=0, pos_y=0, pos_x 0..1023 -> addr_out = 0,1..31, changing every 32 clk,
//   1 clk after pos; in_image=1 throughout.
// 2 Same, pos_y=32..63 -> addr_out 32..63 on that band; pos_y=767 -> addr 736..767.
// 3 mode=2'b01 latched at frame start, pos_y=0 -> pos_x=0 gives addr 31, pos_x=1023 gives
//   addr 0.
// 4 FB_W=20, FB_H=12, SCALE=3 -> pos_x 0,1,2 give addr 0; pos_x=3 gives addr 1;
//   pos_x>=60 gives in_image=0 and pixel_out=BG 2 clk later.
// 5 mode changed at pos_y=100 -> addr unchanged until pos_y wraps; frame_tick high 1 clk
//   only; new mode applies in the next frame.
// 6 rst=0 for 1 clk at pos_x=500 -> outputs 0/BG next clk; correct addr resumes from the
//   next pos_x=0 of the next frame.

Source files
------------

// File: rtl/vga_scaled_fb_reader.sv
// Maps VGA raster positions to integer-scaled, optionally mirrored frame-buffer addresses and gates pixels.
// addr_out is 1 clk after pos_x/pos_y, pixel_out/in_image 2 clk after; no backpressure, one pixel per clk.
module vga_scaled_fb_reader #(
   parameter int              SCREEN_X = 1024,
   parameter int              SCREEN_Y = 768,
   parameter int              FB_W     = 32,
   parameter int              FB_H     = 24,
   parameter int              SCALE    = 32,
   parameter int              AW       = 10,
   parameter int              DW       = 3,
   parameter logic [DW-1:0]   BG_COLOR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [11:0]   pos_x,
   input  logic [11:0]   pos_y,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] pixel_in,
   output logic [AW-1:0] addr_out,
   output logic [DW-1:0] pixel_out,
   output logic          in_image,
   output logic          frame_tick
);

   localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int CXW = $clog2(FB_W + 1);
   localparam int CYW = $clog2(FB_H + 1);

   localparam logic [SW-1:0]  SUB_LAST = SW'(SCALE - 1);
   localparam logic [CXW-1:0] CX_END   = CXW'(FB_W);
   localparam logic [CYW-1:0] CY_END   = CYW'(FB_H);
   localparam logic [11:0]    X_END    = 12'(SCREEN_X);
   localparam logic [11:0]    Y_END    = 12'(SCREEN_Y);
   localparam logic [31:0]    FBW32    = 32'(FB_W);

   logic [11:0]    prev_x_q, prev_y_q;
   logic [SW-1:0]  sub_x_q, sub_x_d, sub_y_q, sub_y_d;
   logic [CXW-1:0] cx_q, cx_d, ex;
   logic [CYW-1:0] cy_q, cy_d, ey;
   logic           x_ok_q, x_ok_d, y_ok_q, y_ok_d;
   logic [1:0]     mode_q, mode_d;
   logic           frame_start;
   logic           in_img1_q, in_img1_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [31:0]    addr_full;
   logic           in_image_q, tick_q;
   logic [DW-1:0]  pix_q;

   always_comb begin
      sub_x_d     = sub_x_q;
      cx_d        = cx_q;
      x_ok_d      = x_ok_q;
      sub_y_d     = sub_y_q;
      cy_d        = cy_q;
      y_ok_d      = y_ok_q;
      frame_start = (pos_y == '0) && (prev_y_q != '0);
      mode_d      = frame_start ? mode : mode_q;

      if (pos_x == '0) begin
         sub_x_d = '0;
         cx_d    = '0;
         x_ok_d  = 1'b1;
      end else if ((pos_x < X_END) && (pos_x == prev_x_q + 12'd1)) begin
         if (sub_x_q == SUB_LAST) begin
            sub_x_d = '0;
            if (cx_q != CX_END) cx_d = cx_q + CXW'(1);
         end else begin
            sub_x_d = sub_x_q + SW'(1);
         end
      end else begin
         x_ok_d = 1'b0;
      end

      // Y only moves on a line change; a skipped line poisons the rest of the frame.
      if (pos_y != prev_y_q) begin
         if (pos_y == '0) begin
            sub_y_d = '0;
            cy_d    = '0;
            y_ok_d  = 1'b1;
         end else if (pos_y == prev_y_q + 12'd1) begin
            if (sub_y_q == SUB_LAST) begin
               sub_y_d = '0;
               if (cy_q != CY_END) cy_d = cy_q + CYW'(1);
            end else begin
               sub_y_d = sub_y_q + SW'(1);
            end
         end else begin
            y_ok_d = 1'b0;
         end
      end

      in_img1_d = x_ok_d && y_ok_d && (cx_d < CX_END) && (cy_d < CY_END) && (pos_y < Y_END);
      ex        = mode_d[0] ? (CXW'(FB_W - 1) - cx_d) : cx_d;
      ey        = mode_d[1] ? (CYW'(FB_H - 1) - cy_d) : cy_d;
      addr_full = 32'(ey) * FBW32 + 32'(ex);
      addr_d    = in_img1_d ? addr_full[AW-1:0] : addr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_x_q   <= '0;
         prev_y_q   <= '0;
         sub_x_q    <= '0;
         cx_q       <= '0;
         x_ok_q     <= 1'b0;
         sub_y_q    <= '0;
         cy_q       <= '0;
         y_ok_q     <= 1'b0;
         mode_q     <= '0;
         in_img1_q  <= 1'b0;
         addr_q     <= '0;
         in_image_q <= 1'b0;
         pix_q      <= BG_COLOR;
         tick_q     <= 1'b0;
      end else begin
         prev_x_q   <= pos_x;
         prev_y_q   <= pos_y;
         sub_x_q    <= sub_x_d;
         cx_q       <= cx_d;
         x_ok_q     <= x_ok_d;
         sub_y_q    <= sub_y_d;
         cy_q       <= cy_d;
         y_ok_q     <= y_ok_d;
         mode_q     <= mode_d;
         in_img1_q  <= in_img1_d;
         addr_q     <= addr_d;
         in_image_q <= in_img1_q;
         pix_q      <= in_img1_q ? pixel_in : BG_COLOR;
         tick_q     <= frame_start;
      end
   end

   assign addr_out   = addr_q;
   assign pixel_out  = pix_q;
   assign in_image   = in_image_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_scaled_fb_reader.sv
// Randomised raster stimulus into a default-sized and a small-scale reader, checked against a division-based model.
module tb_vga_scaled_fb_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [11:0] pos_x, pos_y;
   logic [1:0]  mode;
   logic [9:0]  addr_a, addr_b;
   logic [2:0]  pin_a, pin_b, pout_a, pout_b;
   logic        img_a, img_b, tick_a, tick_b;

   function automatic logic [2:0] ram_word(input int k, input logic [9:0] a);
      logic [9:0] h;
      h = a ^ (a >> 3) ^ (a >> 6) ^ 10'(k * 5);
      return h[2:0];
   endfunction

   assign pin_a = ram_word(0, addr_a);
   assign pin_b = ram_word(1, addr_b);

   vga_scaled_fb_reader u_big (
      .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .mode(mode),
      .pixel_in(pin_a), .addr_out(addr_a), .pixel_out(pout_a),
      .in_image(img_a), .frame_tick(tick_a)
   );

   vga_scaled_fb_reader #(.FB_W(20), .FB_H(12), .SCALE(3)) u_small (
      .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .mode(mode),
      .pixel_in(pin_b), .addr_out(addr_b), .pixel_out(pout_b),
      .in_image(img_b), .frame_tick(tick_b)
   );

   int fbw [2] = '{32, 20};
   int fbh [2] = '{24, 12};
   int scl [2] = '{32, 3};

   int         m_prev_x, m_prev_y;
   bit         m_xg, m_yg, m_tick;
   logic [1:0] m_mode;
   bit         m_img1 [2];
   bit         m_img2 [2];
   logic [9:0] m_addr [2];
   logic [2:0] m_pix2 [2];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 20)
            $display("FAIL %s: got %0h expected %0h (t=%0t x=%0d y=%0d)", tag, obs, exp, $time, m_prev_x, m_prev_y);
      end
   endtask

   task automatic step(input int x, input int y, input logic [1:0] m, input logic r);
      bit fs, img_new;
      int cxv, cyv, ex, ey;
      pos_x = 12'(x);
      pos_y = 12'(y);
      mode  = m;
      rst   = r;
      if (!r) begin
         m_prev_x = 0; m_prev_y = 0; m_xg = 0; m_yg = 0; m_tick = 0; m_mode = 2'b00;
         for (int k = 0; k < 2; k++) begin
            m_img1[k] = 0; m_img2[k] = 0; m_addr[k] = '0; m_pix2[k] = 3'b000;
         end
      end else begin
         fs = (y == 0) && (m_prev_y != 0);
         m_tick = fs;
         if (fs) m_mode = m;
         m_xg = (x == 0) || (m_xg && x < 1024 && x == m_prev_x + 1);
         if (y != m_prev_y) m_yg = (y == 0) || (m_yg && y == m_prev_y + 1);
         for (int k = 0; k < 2; k++) begin
            m_img2[k] = m_img1[k];
            m_pix2[k] = m_img1[k] ? ram_word(k, m_addr[k]) : 3'b000;
            cxv = x / scl[k];
            cyv = y / scl[k];
            img_new = m_xg && m_yg && y < 768 && cxv < fbw[k] && cyv < fbh[k];
            if (img_new) begin
               ex = m_mode[0] ? fbw[k] - 1 - cxv : cxv;
               ey = m_mode[1] ? fbh[k] - 1 - cyv : cyv;
               m_addr[k] = 10'((ey * fbw[k] + ex) % 1024);
            end
            m_img1[k] = img_new;
         end
         m_prev_x = x;
         m_prev_y = y;
      end
      @(posedge clk);
      #1;
      check("addr_big",  32'(addr_a), 32'(m_addr[0]));
      check("pix_big",   32'(pout_a), 32'(m_pix2[0]));
      check("img_big",   32'(img_a),  32'(m_img2[0]));
      check("tick_big",  32'(tick_a), 32'(m_tick));
      check("addr_sml",  32'(addr_b), 32'(m_addr[1]));
      check("pix_sml",   32'(pout_b), 32'(m_pix2[1]));
      check("img_sml",   32'(img_b),  32'(m_img2[1]));
      check("tick_sml",  32'(tick_b), 32'(m_tick));
   endtask

   task automatic run_line(input int y, input int xlast, input int rst_i, input logic [1:0] fmode);
      int x;
      logic [1:0] m;
      x = 0;
      for (int i = 0; i <= xlast; i++) begin
         if (i > 0 && $urandom_range(0, 63) == 0) x = $urandom_range(1, 1100);
         m = (y == 0 && i == 0) ? fmode : 2'($urandom);
         step(x, y, m, (i == rst_i) ? 1'b0 : 1'b1);
         x++;
      end
   endtask

   task automatic run_frame(input logic [1:0] fmode, input int rst_y, input bit yjump);
      for (int y = 0; y < 771; y++) begin
         int xl;
         if (yjump && y >= 400 && y < 600) continue;
         xl = (y == 0 || y == 32 || y == 100 || y == 767) ? 1030 : $urandom_range(0, 5);
         run_line(y, xl, (y == rst_y) ? 500 : -1, fmode);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 1'b0);
      step(0, 767, 2'b11, 1'b1);
      run_frame(2'b00, -1, 1'b0);
      run_frame(2'b01, -1, 1'b0);
      run_frame(2'b10, 100, 1'b0);
      run_frame(2'b11, -1, 1'b1);
      run_frame(2'b00, -1, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
